stream_arbiter: RTL and testbench



---
 rtl/stream_arbiter.sv | 108 ++++++++++
 tb/tb_stream_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// Round-robin stream arbiter: grants one channel at a time for up to MAXLEN words,
// separates blocks with idle control words and injects a single trigger token on request.
module stream_arbiter #(
   parameter int            NCH    = 16,
   parameter int            DW     = 16,
   parameter int            MAXLEN = 512,
   parameter logic [DW-1:0] IDLE_K = DW'(16'h50BC),
   parameter logic [DW-1:0] TRIG_K = DW'(16'h1CBC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH*DW-1:0] data,
   input  logic [NCH-1:0]    req,
   input  logic              trigger,
   output logic [NCH-1:0]    ack,
   output logic [DW-1:0]     dout,
   output logic              kchar
);

   localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = $clog2(MAXLEN + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAXLEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_TRIG = 2'd2;

   logic [1:0]              state;
   logic                    trig_pend;
   logic [LW-1:0]           last_winner;
   logic [LW-1:0]           winner;
   logic [LW:0]             idx;
   logic [CW-1:0]           count;
   logic [CW-1:0]           count_nxt;
   logic [NCH-1:0][DW-1:0]  words;

   assign words     = data;
   assign count_nxt = count + CW'(1);

   // Walk offsets from farthest to nearest so the nearest requester above last_winner wins.
   always_comb begin
      winner = last_winner;
      idx    = '0;
      for (int i = NCH; i >= 1; i--) begin
         idx = {1'b0, last_winner} + (LW+1)'(i);
         if (idx >= (LW+1)'(NCH)) idx = idx - (LW+1)'(NCH);
         if (req[idx[LW-1:0]]) winner = idx[LW-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         ack         <= '0;
         dout        <= IDLE_K;
         kchar       <= 1'b1;
         trig_pend   <= 1'b0;
         count       <= '0;
         last_winner <= LW'(NCH - 1);
      end else begin
         // A trigger arriving while the token goes out re-arms for another token.
         trig_pend <= (state == S_TRIG) ? trigger : (trig_pend | trigger);
         case (state)
            S_IDLE: begin
               dout  <= IDLE_K;
               kchar <= 1'b1;
               if (trig_pend) begin
                  state <= S_TRIG;
                  dout  <= TRIG_K;
               end else if (|req) begin
                  state       <= S_XFER;
                  ack         <= {{(NCH-1){1'b0}}, 1'b1} << winner;
                  last_winner <= winner;
                  count       <= '0;
               end
            end
            S_XFER: begin
               if (req[last_winner]) begin
                  dout  <= words[last_winner];
                  kchar <= 1'b0;
                  count <= count_nxt;
                  if (count_nxt == MAXC) begin
                     ack   <= '0;
                     state <= S_IDLE;
                  end
               end else begin
                  dout  <= IDLE_K;
                  kchar <= 1'b1;
                  ack   <= '0;
                  state <= S_IDLE;
               end
            end
            S_TRIG: begin
               dout  <= IDLE_K;
               kchar <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               dout  <= IDLE_K;
               kchar <= 1'b1;
               ack   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: directed scenarios with fixed expectations plus a random run
// compared each cycle against a rule-level model of the grant/trigger behaviour.
module tb_stream_arbiter;

   localparam int NCH    = 16;
   localparam int DW     = 16;
   localparam int MAXLEN = 4;
   localparam logic [15:0] IK = 16'h50BC;
   localparam logic [15:0] TK = 16'h1CBC;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NCH*DW-1:0] data = '0;
   logic [NCH-1:0]    req = '0;
   logic              trigger = 1'b0;
   logic [NCH-1:0]    ack;
   logic [DW-1:0]     dout;
   logic              kchar;

   int n_tests = 0;
   int n_fail  = 0;

   // model: owner = granted channel or -1, sending_trig = token cycle in progress
   int          m_owner, m_last, m_sent;
   bit          m_pend, m_sending_trig;
   logic [15:0] m_ack, m_dout;
   logic        m_k;

   stream_arbiter #(.NCH(NCH), .DW(DW), .MAXLEN(MAXLEN), .IDLE_K(IK), .TRIG_K(TK)) dut (
      .clk(clk), .reset(reset), .data(data), .req(req), .trigger(trigger),
      .ack(ack), .dout(dout), .kchar(kchar)
   );

   always #5 clk = ~clk;

   function automatic int pick(logic [NCH-1:0] r, int last);
      for (int o = 1; o <= NCH; o++) if (r[(last + o) % NCH]) return (last + o) % NCH;
      return -1;
   endfunction

   function automatic logic [15:0] word_of(int ch);
      return data[ch*DW +: DW];
   endfunction

   task automatic model_step();
      bit np;
      if (reset) begin
         m_owner = -1; m_sending_trig = 0; m_pend = 0; m_last = NCH - 1; m_sent = 0;
         m_ack = '0; m_dout = IK; m_k = 1'b1;
         return;
      end
      np = m_sending_trig ? trigger : (m_pend | trigger);
      if (m_sending_trig) begin
         m_sending_trig = 0; m_dout = IK; m_k = 1'b1;
      end else if (m_owner >= 0) begin
         if (req[m_owner]) begin
            m_dout = word_of(m_owner); m_k = 1'b0; m_sent++;
            if (m_sent == MAXLEN) begin m_ack = '0; m_owner = -1; end
         end else begin
            m_dout = IK; m_k = 1'b1; m_ack = '0; m_owner = -1;
         end
      end else begin
         m_dout = IK; m_k = 1'b1;
         if (m_pend) begin
            m_sending_trig = 1; m_dout = TK;
         end else if (req != 0) begin
            m_owner = pick(req, m_last); m_last = m_owner; m_sent = 0;
            m_ack = '0; m_ack[m_owner] = 1'b1;
         end
      end
      m_pend = np;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; req = '1; trigger = 1;
      tick(); tick();
      n_tests++;
      if (ack !== 16'h0 || dout !== IK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hold: ack=%h dout=%h kchar=%b, want 0000 %h 1", ack, dout, kchar, IK);
      end
      reset = 0; req = '0; trigger = 0;
      tick();
      n_tests++;
      if (ack !== 16'h0 || dout !== IK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: ack=%h dout=%h kchar=%b, want 0000 %h 1", ack, dout, kchar, IK);
      end
      tick();
      n_tests++;
      if (dout !== IK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL no_trig_after_reset: dout=%h kchar=%b, want %h 1", dout, kchar, IK);
      end
   endtask

   task automatic test_single();
      for (int c = 0; c < NCH; c++) data[c*DW +: DW] = 16'($urandom);
      data[2*DW +: DW] = 16'h1234;
      req = 16'h0004;
      tick();
      n_tests++;
      if (ack !== 16'h0004 || dout !== IK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant: ack=%h dout=%h kchar=%b, want 0004 %h 1", ack, dout, kchar, IK);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_tests++;
         if (ack !== 16'h0004 || dout !== 16'h1234 || kchar !== 1'b0) begin
            n_fail++;
            $display("FAIL single_word%0d: ack=%h dout=%h kchar=%b, want 0004 1234 0", k, ack, dout, kchar);
         end
      end
      req = '0;
      tick();
      n_tests++;
      if (ack !== 16'h0 || dout !== IK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL single_end: ack=%h dout=%h kchar=%b, want 0000 %h 1", ack, dout, kchar, IK);
      end
      tick();
   endtask

   task automatic test_alternate();
      logic [15:0] e;
      int ch;
      data[0*DW +: DW] = 16'hA0A0;
      data[2*DW +: DW] = 16'hB2B2;
      req = 16'h0005;
      for (int g = 0; g < 4; g++) begin
         ch = (g % 2 == 0) ? 0 : 2;
         e = '0; e[ch] = 1'b1;
         tick();
         n_tests++;
         if (ack !== e || dout !== IK || kchar !== 1'b1) begin
            n_fail++;
            $display("FAIL alt_grant%0d: ack=%h dout=%h kchar=%b, want %h %h 1", g, ack, dout, kchar, e, IK);
         end
         for (int w = 1; w <= MAXLEN; w++) begin
            tick();
            n_tests++;
            if (ack !== ((w < MAXLEN) ? e : 16'h0) || dout !== word_of(ch) || kchar !== 1'b0) begin
               n_fail++;
               $display("FAIL alt_word g%0d w%0d: ack=%h dout=%h kchar=%b, want %h %h 0",
                        g, w, ack, dout, kchar, (w < MAXLEN) ? e : 16'h0, word_of(ch));
            end
         end
      end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_trigger();
      data[5*DW +: DW] = 16'h5555;
      req = 16'h0020;
      tick();
      n_tests++;
      if (ack !== 16'h0020) begin
         n_fail++;
         $display("FAIL trig_grant: ack=%h, want 0020", ack);
      end
      tick();
      trigger = 1;
      tick();
      trigger = 0;
      tick(); tick();
      n_tests++;
      if (ack !== 16'h0 || dout !== 16'h5555 || kchar !== 1'b0) begin
         n_fail++;
         $display("FAIL trig_block_end: ack=%h dout=%h kchar=%b, want 0000 5555 0", ack, dout, kchar);
      end
      tick();
      n_tests++;
      if (ack !== 16'h0 || dout !== TK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL trig_token: ack=%h dout=%h kchar=%b, want 0000 %h 1", ack, dout, kchar, TK);
      end
      tick();
      n_tests++;
      if (ack !== 16'h0 || dout !== IK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL trig_after: ack=%h dout=%h kchar=%b, want 0000 %h 1", ack, dout, kchar, IK);
      end
      tick();
      n_tests++;
      if (ack !== 16'h0020 || dout !== IK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL trig_regrant: ack=%h dout=%h kchar=%b, want 0020 %h 1", ack, dout, kchar, IK);
      end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_double_trigger();
      int ntk;
      data[7*DW +: DW] = 16'h7777;
      req = 16'h0080;
      tick();
      trigger = 1;
      tick();
      trigger = 0;
      tick(); tick();
      trigger = 1;
      tick();
      trigger = 0;
      ntk = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (dout === TK && kchar === 1'b1) ntk++;
      end
      n_tests++;
      if (ntk !== 1) begin
         n_fail++;
         $display("FAIL double_trig_count: saw %0d trigger tokens, want 1", ntk);
      end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_reset_midxfer();
      data[3*DW +: DW] = 16'h3333;
      data[0*DW +: DW] = 16'h0C0C;
      req = 16'h0008;
      tick(); tick();
      n_tests++;
      if (ack !== 16'h0008 || dout !== 16'h3333 || kchar !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_word1: ack=%h dout=%h kchar=%b, want 0008 3333 0", ack, dout, kchar);
      end
      #2 reset = 1;
      #1;
      n_tests++;
      if (ack !== 16'h0 || dout !== IK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_async: ack=%h dout=%h kchar=%b, want 0000 %h 1", ack, dout, kchar, IK);
      end
      req = 16'hFFFF;
      tick();
      n_tests++;
      if (ack !== 16'h0 || dout !== IK || kchar !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_held: ack=%h dout=%h kchar=%b, want 0000 %h 1", ack, dout, kchar, IK);
      end
      reset = 0;
      tick();
      n_tests++;
      if (ack !== 16'h0001) begin
         n_fail++;
         $display("FAIL rst_first_ch0: ack=%h, want 0001", ack);
      end
      tick();
      n_tests++;
      if (dout !== 16'h0C0C || kchar !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ch0_word: dout=%h kchar=%b, want 0c0c 0", dout, kchar);
      end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_wrap();
      req = 16'h8000;
      tick();
      n_tests++;
      if (ack !== 16'h8000) begin
         n_fail++;
         $display("FAIL wrap_grant15: ack=%h, want 8000", ack);
      end
      req = '0;
      tick(); tick();
      req = 16'h8001;
      tick();
      n_tests++;
      if (ack !== 16'h0001) begin
         n_fail++;
         $display("FAIL wrap_ch0: ack=%h, want 0001", ack);
      end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_random();
      reset = 1;
      tick();
      reset = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(3) == 0) req = 16'($urandom & $urandom);
         if ($urandom_range(7) == 0) req = '0;
         trigger = ($urandom_range(9) == 0);
         for (int c = 0; c < NCH; c++) data[c*DW +: DW] = 16'($urandom);
         reset = ($urandom_range(299) == 0);
         tick();
         n_tests++;
         if (ack !== m_ack || dout !== m_dout || kchar !== m_k) begin
            n_fail++;
            $display("FAIL random cyc%0d: ack=%h dout=%h kchar=%b, want %h %h %b",
                     cyc, ack, dout, kchar, m_ack, m_dout, m_k);
         end
         n_tests++;
         if ($countones(ack) > 1) begin
            n_fail++;
            $display("FAIL random_onehot cyc%0d: ack=%h, want at most one bit", cyc, ack);
         end
      end
      reset = 0; trigger = 0; req = '0;
   endtask

   initial begin
      model_step();
      test_reset();
      test_single();
      test_alternate();
      test_trigger();
      test_double_trigger();
      test_reset_midxfer();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
